// File: rtl/vga_sram_display_ctrl_if.sv
// SRAM read port and VGA DAC pins of the frame-buffer display controller.
// The controller drives everything except SRAM_DQ, which the SRAM returns.
interface vga_sram_display_ctrl_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [15:0]       SRAM_DQ;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;
  logic              SRAM_WE_N;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;
  logic [7:0]        VGA_R;
  logic [7:0]        VGA_G;
  logic [7:0]        VGA_B;
  logic              VGA_HS;
  logic              VGA_VS;
  logic              VGA_BLANK_N;
  logic              VGA_SYNC_N;
  logic              VGA_CLK;

  modport master (
    output SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK,
    input  SRAM_DQ
  );

  modport slave (
    input  SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK,
    output SRAM_DQ
  );
endinterface

// File: rtl/vga_sram_display_ctrl.sv
// Scans an RGB565 frame buffer out of async SRAM onto a VGA DAC through a
// two-stage pipeline (address, then data), with frame-synchronous vertical scroll.
module vga_sram_display_ctrl #(
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int ADDR_W = 20
) (
  input  logic                    pixel_clk,
  input  logic                    rst_n,
  input  logic                    S,
  input  logic                    R,
  input  logic                    stop,
  vga_sram_display_ctrl_if.master bus
);
  localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW     = $clog2(H_TOT);
  localparam int VW     = $clog2(V_TOT);
  localparam int HS_BEG = H_ACT + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACT + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;

  logic [HW-1:0]     r_h;
  logic [VW-1:0]     r_v;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;
  logic              r_run;
  logic              r_pend;
  logic              r_act1, r_hs1, r_vs1;
  logic              r_act2, r_hs2, r_vs2;
  logic [7:0]        r_red, r_grn, r_blu;

  logic              w_h_end, w_v_end, w_frame_end;
  logic              w_act0, w_hs0, w_vs0;
  logic [ADDR_W-1:0] w_pix_addr;

  assign w_h_end     = (r_h == HW'(H_TOT - 1));
  assign w_v_end     = (r_v == VW'(V_TOT - 1));
  assign w_frame_end = w_h_end && w_v_end;
  assign w_act0      = (r_h < HW'(H_ACT)) && (r_v < VW'(V_ACT));
  assign w_hs0       = !((r_h >= HW'(HS_BEG)) && (r_h < HW'(HS_END)));
  assign w_vs0       = !((r_v >= VW'(VS_BEG)) && (r_v < VW'(VS_END)));
  assign w_pix_addr  = r_base + ADDR_W'(r_v) * ADDR_W'(H_ACT) + ADDR_W'(r_h);

  // Raster position counters
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= {HW{1'b0}};
      r_v <= {VW{1'b0}};
    end else if (w_h_end) begin
      r_h <= {HW{1'b0}};
      r_v <= w_v_end ? {VW{1'b0}} : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  // Scroll control; base only moves at frame end so a frame never tears
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run  <= 1'b0;
      r_pend <= 1'b0;
      r_base <= {ADDR_W{1'b0}};
    end else begin
      if (R) begin
        r_run <= 1'b0;
      end else if (S) begin
        r_run <= 1'b1;
      end
      if (R) begin
        r_pend <= 1'b1;
      end else if (w_frame_end) begin
        r_pend <= 1'b0;
      end
      if (w_frame_end) begin
        if (r_pend || R) begin
          r_base <= {ADDR_W{1'b0}};
        end else if (r_run && !stop) begin
          r_base <= r_base + ADDR_W'(H_ACT);
        end
      end
    end
  end

  // Stage 1: present the SRAM address, delay the timing flags
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= {ADDR_W{1'b0}};
      r_act1 <= 1'b0;
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
    end else begin
      if (w_act0) begin
        r_addr <= w_pix_addr;
      end
      r_act1 <= w_act0;
      r_hs1  <= w_hs0;
      r_vs1  <= w_vs0;
    end
  end

  // Stage 2: capture SRAM data and expand RGB565 to 8 bits per channel
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_red  <= 8'h00;
      r_grn  <= 8'h00;
      r_blu  <= 8'h00;
      r_act2 <= 1'b0;
      r_hs2  <= 1'b1;
      r_vs2  <= 1'b1;
    end else begin
      r_red  <= r_act1 ? {bus.SRAM_DQ[15:11], bus.SRAM_DQ[15:13]} : 8'h00;
      r_grn  <= r_act1 ? {bus.SRAM_DQ[10:5],  bus.SRAM_DQ[10:9]}  : 8'h00;
      r_blu  <= r_act1 ? {bus.SRAM_DQ[4:0],   bus.SRAM_DQ[4:2]}   : 8'h00;
      r_act2 <= r_act1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
    end
  end

  assign bus.SRAM_ADDR   = r_addr;
  assign bus.SRAM_CE_N   = 1'b0;
  assign bus.SRAM_OE_N   = 1'b0;
  assign bus.SRAM_WE_N   = 1'b1;
  assign bus.SRAM_UB_N   = 1'b0;
  assign bus.SRAM_LB_N   = 1'b0;
  assign bus.VGA_R       = r_red;
  assign bus.VGA_G       = r_grn;
  assign bus.VGA_B       = r_blu;
  assign bus.VGA_HS      = r_hs2;
  assign bus.VGA_VS      = r_vs2;
  assign bus.VGA_BLANK_N = r_act2;
  assign bus.VGA_SYNC_N  = 1'b0;
  assign bus.VGA_CLK     = ~pixel_clk;
endmodule

// File: tb/tb_vga_sram_display_ctrl.sv
// Bench for vga_sram_display_ctrl using a shrunken raster (15x8, 120-cycle frame)
// and a 6-bit address so scroll wrap-around is reachable.
module tb_vga_sram_display_ctrl;
  localparam int H_ACT = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int V_ACT = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int AW = 6;
  localparam int HT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;

  logic pixel_clk = 1'b0;
  logic rst_n = 1'b0;
  logic S = 1'b0, R = 1'b0, stop = 1'b0;

  vga_sram_display_ctrl_if #(.ADDR_W(AW)) bus ();

  vga_sram_display_ctrl #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .ADDR_W(AW)
  ) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .S(S), .R(R), .stop(stop), .bus(bus.master)
  );

  always #20 pixel_clk = ~pixel_clk;

  typedef struct { logic [7:0] r, g, b; logic hs, vs, blank; } exp_t;
  typedef struct { logic [15:0] dq; logic [7:0] r, g, b; } vec_t;

  exp_t sb[$];
  exp_t last_exp;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int mh, mv;
  logic [AW-1:0] mbase, m1_addr;
  logic mrun, mpend, m1_act, m1_hs, m1_vs;
  int hs_fall1, hs_rise1, vs_fall1, vs_rise1, vs_fall2;
  logic prev_hs, prev_vs;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; mbase = '0; m1_addr = '0; mrun = 1'b0; mpend = 1'b0;
    m1_act = 1'b0; m1_hs = 1'b1; m1_vs = 1'b1; cyc = 0; sb.delete();
    hs_fall1 = -1; hs_rise1 = -1; vs_fall1 = -1; vs_rise1 = -1; vs_fall2 = -1;
    prev_hs = 1'b1; prev_vs = 1'b1;
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_addr"}, 32'(bus.SRAM_ADDR), 32'd0);
    chk({tag, "_rgb"}, {8'h00, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'd0);
    chk({tag, "_hs_vs_blank"}, {29'd0, bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N}, 32'b110);
  endtask

  // One pixel clock: drive inputs at a negedge, advance the model, compare at the next negedge.
  task automatic step(input logic s, input logic r, input logic st, input logic [15:0] dq);
    exp_t e;
    logic a0, h0, v0, fe;
    logic [23:0] c;
    S = s; R = r; stop = st; bus.SRAM_DQ = dq;
    c = expand(dq);
    e.blank = m1_act; e.hs = m1_hs; e.vs = m1_vs;
    e.r = m1_act ? c[23:16] : 8'h00;
    e.g = m1_act ? c[15:8]  : 8'h00;
    e.b = m1_act ? c[7:0]   : 8'h00;
    sb.push_back(e);
    a0 = (mh < H_ACT) && (mv < V_ACT);
    h0 = !((mh >= H_ACT + H_FP) && (mh < H_ACT + H_FP + H_SYNC));
    v0 = !((mv >= V_ACT + V_FP) && (mv < V_ACT + V_FP + V_SYNC));
    if (a0) m1_addr = mbase + AW'(mv * H_ACT + mh);
    m1_act = a0; m1_hs = h0; m1_vs = v0;
    fe = (mh == HT - 1) && (mv == VT - 1);
    if (fe) begin
      if (mpend || r) mbase = '0;
      else if (mrun && !st) mbase = mbase + AW'(H_ACT);
    end
    if (r) mpend = 1'b1; else if (fe) mpend = 1'b0;
    if (r) mrun = 1'b0; else if (s) mrun = 1'b1;
    if (mh == HT - 1) begin mh = 0; mv = (mv == VT - 1) ? 0 : mv + 1; end
    else mh = mh + 1;
    @(negedge pixel_clk);
    cyc++;
    e = sb.pop_front();
    last_exp = e;
    chk("rgb", {8'h00, bus.VGA_R, bus.VGA_G, bus.VGA_B}, {8'h00, e.r, e.g, e.b});
    chk("hs_vs_blank", {29'd0, bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N}, {29'd0, e.hs, e.vs, e.blank});
    chk("sram_addr", 32'(bus.SRAM_ADDR), 32'(m1_addr));
    chk("strobes", {26'd0, bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N, bus.SRAM_UB_N,
                    bus.SRAM_LB_N, bus.VGA_SYNC_N}, 32'b001000);
    if (prev_hs && !bus.VGA_HS && hs_fall1 < 0) hs_fall1 = cyc;
    if (!prev_hs && bus.VGA_HS && hs_fall1 >= 0 && hs_rise1 < 0) hs_rise1 = cyc;
    if (prev_vs && !bus.VGA_VS) begin
      if (vs_fall1 < 0) vs_fall1 = cyc;
      else if (vs_fall2 < 0) vs_fall2 = cyc;
    end
    if (!prev_vs && bus.VGA_VS && vs_fall1 >= 0 && vs_rise1 < 0) vs_rise1 = cyc;
    prev_hs = bus.VGA_HS; prev_vs = bus.VGA_VS;
  endtask

  // Runs until the stage-1 address holds pixel (0,0) of the next frame.
  task automatic frame_start(input logic st);
    int n = 0;
    do begin
      step(1'b0, 1'b0, st, 16'($urandom));
      n++;
    end while (!(mh == 1 && mv == 0) && n < 2 * FRAME);
    if (n >= 2 * FRAME) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_timeout: got %0d cycles, want < %0d", n, 2 * FRAME);
    end
  endtask

  initial begin
    vec_t tbl[6];
    logic [AW-1:0] wrap_exp[4];
    int n;
    tbl[0] = '{16'hF800, 8'hFF, 8'h00, 8'h00};
    tbl[1] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[2] = '{16'h0841, 8'h08, 8'h08, 8'h08};
    tbl[3] = '{16'h07E0, 8'h00, 8'hFF, 8'h00};
    tbl[4] = '{16'h001F, 8'h00, 8'h00, 8'hFF};
    tbl[5] = '{16'h0000, 8'h00, 8'h00, 8'h00};
    wrap_exp[0] = 6'd48; wrap_exp[1] = 6'd56; wrap_exp[2] = 6'd0; wrap_exp[3] = 6'd8;

    model_reset();
    bus.SRAM_DQ = 16'h0000;
    repeat (3) @(negedge pixel_clk);
    chk_reset_pins("reset");
    rst_n = 1'b1;

    // Raster timing with an incrementing data pattern
    for (int i = 0; i < 2 * FRAME + 10; i++) step(1'b0, 1'b0, 1'b0, 16'(i));
    chk("hs_first_low", 32'(hs_fall1), 32'(H_ACT + H_FP + 2));
    chk("hs_width", 32'(hs_rise1 - hs_fall1), 32'(H_SYNC));
    chk("vs_first_low", 32'(vs_fall1), 32'((V_ACT + V_FP) * HT + 2));
    chk("vs_width", 32'(vs_rise1 - vs_fall1), 32'(V_SYNC * HT));
    chk("frame_period", 32'(vs_fall2 - vs_fall1), 32'(FRAME));

    // Colour decode table, checked on an active pixel
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin
        step(1'b0, 1'b0, 1'b0, tbl[k].dq);
        n++;
      end while (!last_exp.blank && n < 200);
      chk("tbl_blank_n", {31'd0, bus.VGA_BLANK_N}, 32'd1);
      chk("tbl_rgb", {8'h00, bus.VGA_R, bus.VGA_G, bus.VGA_B}, {8'h00, tbl[k].r, tbl[k].g, tbl[k].b});
    end
    n = 0;
    do begin
      step(1'b0, 1'b0, 1'b0, 16'hFFFF);
      n++;
    end while (last_exp.blank && n < 200);
    chk("blank_rgb", {8'h00, bus.VGA_R, bus.VGA_G, bus.VGA_B, 7'd0, bus.VGA_BLANK_N}, 32'd0);

    // Scrolling: idle, single-cycle S pulse, stop hold, wrap-around
    frame_start(1'b0);
    chk("idle_base", 32'(bus.SRAM_ADDR), 32'd0);
    step(1'b1, 1'b0, 1'b0, 16'h1234);
    frame_start(1'b0);
    chk("scroll_f2", 32'(bus.SRAM_ADDR), 32'd8);
    frame_start(1'b0);
    chk("scroll_f3", 32'(bus.SRAM_ADDR), 32'd16);
    frame_start(1'b1);
    chk("stop_f1", 32'(bus.SRAM_ADDR), 32'd16);
    frame_start(1'b1);
    chk("stop_f2", 32'(bus.SRAM_ADDR), 32'd16);
    frame_start(1'b0);
    chk("unstop", 32'(bus.SRAM_ADDR), 32'd24);
    frame_start(1'b0);
    chk("scroll_32", 32'(bus.SRAM_ADDR), 32'd32);
    frame_start(1'b0);
    chk("scroll_40", 32'(bus.SRAM_ADDR), 32'd40);
    for (int k = 0; k < 4; k++) begin
      frame_start(1'b0);
      chk("scroll_wrap", 32'(bus.SRAM_ADDR), 32'(wrap_exp[k]));
    end

    // S and R together: R wins, base clears at the next frame end
    step(1'b1, 1'b1, 1'b0, 16'h5555);
    frame_start(1'b0);
    chk("sr_clear", 32'(bus.SRAM_ADDR), 32'd0);
    frame_start(1'b0);
    chk("sr_stays", 32'(bus.SRAM_ADDR), 32'd0);

    // Asynchronous reset in the middle of an active line
    step(1'b1, 1'b0, 1'b0, 16'hFFFF);
    frame_start(1'b0);
    for (int i = 0; i < HT + 3; i++) step(1'b0, 1'b0, 1'b0, 16'hFFFF);
    #5 rst_n = 1'b0;
    #1 chk_reset_pins("midline_reset");
    @(negedge pixel_clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < HT + 4; i++) step(1'b0, 1'b0, 1'b0, 16'($urandom));
    frame_start(1'b0);
    chk("post_reset_base", 32'(bus.SRAM_ADDR), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_sram_display_ctrl.md
Name: vga_sram_display_ctrl

Overview:
- Reads a 640x480 RGB565 frame buffer from the DE2-115 16-bit async SRAM and drives the ADV7123 VGA DAC at 25 MHz pixel clock.
- Sits between the UART-fed SRAM (written elsewhere, read-only here) and the VGA connector.
- S/R/stop inputs control vertical scrolling of the displayed window through SRAM.

Parameters:
- H_ACT 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal timing in pixels (total 800).
- V_ACT 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines (total 525).
- ADDR_W 20: SRAM word-address width.

Ports:
- pixel_clk  in  1  25 MHz pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- SRAM_DQ  in  16  SRAM read data, RGB565.
- S  in  1  synchronous set of run flag (start scrolling).
- R  in  1  synchronous clear of run flag and scroll base.
- stop  in  1  level; freezes scroll base while high.
- SRAM_ADDR  out  20  SRAM word address.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM strobes.
- VGA_R, VGA_G, VGA_B  out  8 each  colour.
- VGA_HS, VGA_VS  out  1 each  syncs, active low.
- VGA_BLANK_N  out  1  low outside active area.
- VGA_SYNC_N  out  1  constant 0.
- VGA_CLK  out  1  inverted pixel_clk.

Behaviour:
- Reset (async, rst_n=0): h=0, v=0, base=0, run=0, SRAM_ADDR=0, RGB=0, HS=1, VS=1, BLANK_N=0.
- Counters: h 0..799, wraps to 0 and increments v; v 0..524, wraps to 0.
- Active when h<640 and v<480.
- HS low for h 656..751; VS low for v 490..491 (both in stage-0 terms).
- SRAM strobes constant: CE_N=0, OE_N=0, WE_N=1, UB_N=0, LB_N=0. The block never drives SRAM_DQ.
- Stage 1 (registered from counters): SRAM_ADDR = (base + v*640 + h) mod 2^20 when active; otherwise holds last value. Also delays active/HS/VS by one stage.
- Stage 2: SRAM_DQ is sampled on the edge after SRAM_ADDR updates. VGA_R={d[15:11],d[15:13]}, VGA_G={d[10:5],d[10:9]}, VGA_B={d[4:0],d[4:2]} when delayed active, else 0.
- HS, VS and BLANK_N are delayed two cycles so they align with RGB. Total pipeline latency counter→pins = 2 cycles.
- run flag: R=1 clears run (R dominates S); else S=1 sets run; else hold.
- R=1 also sets pending base=0.
- Scroll rule: at frame end (h=799, v=524), if run=1 and stop=0, base += 640 mod 2^20.
- base changes only at frame end, so no tearing. An R clear applies at the next frame end, alongside the run clear.
- S, R and stop are sampled every cycle; single-cycle pulses must register.
- Reset mid-frame restarts timing at (0,0) immediately.

Test Plan:
- Reset then release; SRAM_DQ increments each cycle → first HS low 658 cycles after release (656+2). First VS low at line 490+2-cycle offset. Frame period exactly 420000 cycles; HS low width 96, VS low width 1600 cycles.
- SRAM_DQ=16'hF800 constant → active pixels R=FF, G=00, B=00. Blanking → all zero and BLANK_N=0.
- SRAM_DQ=16'hFFFF → RGB FF,FF,FF. SRAM_DQ=16'h0841 → R=08, G=08, B=08.
- Pulse S for 1 cycle, stop=0 → SRAM_ADDR at frame 2 pixel (0,0) = 640; frame 3 = 1280. Strobes remain constant throughout.
- Hold stop=1 with run=1 over two frames → base unchanged. Release stop → next frame advances by 640.
- Pulse S and R in the same cycle → run stays 0, next frame base=0. Assert rst_n=0 mid-line → all outputs return to reset values immediately (asynchronously).
